// File: rtl/fpu_pkg.sv
// fpu_pkg: types and constants shared by the FP write-back stage.
//   FLAG_* : bit indices of the ALU status flags
//   fpu_wb_entry_t : one queued write-back entry {result, dest, flags}
//   fpu_wb_state_t : write-back FSM states
package fpu_pkg;

   localparam int FLAG_ZERO = 6;
   localparam int FLAG_DBZ  = 5;
   localparam int FLAG_QNAN = 4;
   localparam int FLAG_SNAN = 3;
   localparam int FLAG_NX   = 2;
   localparam int FLAG_UDF  = 1;
   localparam int FLAG_OVF  = 0;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  dest;
      logic [6:0]  flags;
   } fpu_wb_entry_t;

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } fpu_wb_state_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// fpu_wb_fifo: DEPTH-entry FIFO of write-back entries.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write din at the tail (caller guarantees !full)
//   pop        : drop the head entry (caller guarantees !empty)
//   flush      : discard all entries, pointers back to 0
//   full, empty: occupancy status
//   head       : entry at the read pointer (all zero after reset)
module fpu_wb_fifo
   import fpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fpu_wb_entry_t din,
   output logic          full,
   output logic          empty,
   output fpu_wb_entry_t head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fpu_wb_entry_t    mem [DEPTH];
   logic [AW-1:0]    rptr, wptr;
   logic [AW:0]      count;

   // Storage is reset too so the presented payload reads as zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= din;
            wptr      <= wptr + AW'(1);
         end
         if (pop) rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rptr];

endmodule

// File: rtl/fpu_writeback_stage.sv
// fpu_writeback_stage: queues FP ALU results and retires them to the FP
// register-file write port; keeps the sticky FCSR exception bits.
// Optional macro FPU_TRAP_EN adds a precise trap on enabled exceptions.
//   in_valid/in_ready, in_result/in_dest/in_flags : ALU result input
//   wb_valid/wb_ready, wb_data/wb_dest/wb_zero    : register-file write port
//   fcsr_clr, fcsr_flags                          : sticky exception flags
//   trap_mask, trap, trap_cause, trap_ack         : trap interface (FPU_TRAP_EN)
module fpu_writeback_stage
   import fpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_result,
   input  logic [4:0]  in_dest,
   input  logic [6:0]  in_flags,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_dest,
   output logic        wb_zero,
`ifdef FPU_TRAP_EN
   input  logic [5:0]  trap_mask,
   output logic        trap,
   output logic [5:0]  trap_cause,
   input  logic        trap_ack,
`endif
   input  logic        fcsr_clr,
   output logic [5:0]  fcsr_flags
);

   fpu_wb_entry_t din, head;
   logic          full, empty, push, pop, flush;
   logic          trap_hit;
   fpu_wb_state_t state;

   assign din = '{result: in_result, dest: in_dest, flags: in_flags};

   fpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (din),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

`ifdef FPU_TRAP_EN
   fpu_wb_state_t state_nxt;

   // Head carries an enabled exception: it is withheld from the write port
   // and the FSM moves to TRAP on the next edge.
   assign trap_hit = (state == RUN) && !empty && |(head.flags[5:0] & trap_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         trap_cause <= '0;
      end else begin
         state <= state_nxt;
         if (trap_hit) trap_cause <= head.flags[5:0] & trap_mask;
      end
   end

   always_comb begin
      state_nxt = state;
      flush     = 1'b0;
      case (state)
         RUN:  if (trap_hit) state_nxt = TRAP;
         TRAP: if (trap_ack) begin
            flush     = 1'b1;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   assign trap = (state == TRAP);
`else
   assign state    = RUN;
   assign trap_hit = 1'b0;
   assign flush    = 1'b0;
`endif

   assign in_ready = !full && (state == RUN);
   assign wb_valid = !empty && (state == RUN) && !trap_hit;
   assign push     = in_valid && in_ready;
   assign pop      = wb_valid && wb_ready;

   assign wb_data = head.result;
   assign wb_dest = head.dest;
   assign wb_zero = head.flags[FLAG_ZERO];

   // Clear takes effect before the retiring (or trapping) entry's flags are
   // merged, so a same-cycle clear keeps only the new flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fcsr_flags <= '0;
      else
         fcsr_flags <= (fcsr_clr ? 6'b0 : fcsr_flags) |
                       ((pop || trap_hit) ? head.flags[5:0] : 6'b0);
   end

endmodule

// File: tb/tb_fpu_writeback_stage.sv
// Testbench for fpu_writeback_stage: a queue-based reference model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_fpu_writeback_stage;
   import fpu_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_result = '0;
   logic [4:0]  in_dest = '0;
   logic [6:0]  in_flags = '0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [31:0] wb_data;
   logic [4:0]  wb_dest;
   logic        wb_zero;
   logic        fcsr_clr = 1'b0;
   logic [5:0]  fcsr_flags;
`ifdef FPU_TRAP_EN
   logic [5:0]  trap_mask = '0;
   logic        trap;
   logic [5:0]  trap_cause;
   logic        trap_ack = 1'b0;
`endif

   fpu_writeback_stage #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_dest    (in_dest),
      .in_flags   (in_flags),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_data    (wb_data),
      .wb_dest    (wb_dest),
      .wb_zero    (wb_zero),
`ifdef FPU_TRAP_EN
      .trap_mask  (trap_mask),
      .trap       (trap),
      .trap_cause (trap_cause),
      .trap_ack   (trap_ack),
`endif
      .fcsr_clr   (fcsr_clr),
      .fcsr_flags (fcsr_flags)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   fpu_wb_entry_t mq[$];
   logic [5:0]    m_fcsr = '0;
   int            n_in = 0, n_out = 0;
`ifdef FPU_TRAP_EN
   bit            m_trap = 1'b0;
   logic [5:0]    m_cause = '0;
   bit            m_h;
`endif
   bit            m_v, m_r;
   logic [5:0]    m_add;

   function automatic bit m_hit();
`ifdef FPU_TRAP_EN
      return !m_trap && (mq.size() != 0) && ((mq[0].flags[5:0] & trap_mask) != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_in_trap();
`ifdef FPU_TRAP_EN
      return m_trap;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_valid();
      return !m_in_trap() && (mq.size() != 0) && !m_hit();
   endfunction

   function automatic bit m_ready();
      return !m_in_trap() && (mq.size() < DEPTH);
   endfunction

   // Inputs change only just after a rising edge, so at the falling edge they
   // already hold what the next rising edge will sample: compare, then advance.
   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_fcsr = '0;
`ifdef FPU_TRAP_EN
         m_trap  = 1'b0;
         m_cause = '0;
`endif
      end else begin
         m_v = m_valid();
         m_r = m_ready();
         chk("in_ready", in_ready, m_r);
         chk("wb_valid", wb_valid, m_v);
         if (m_v) begin
            chk("wb_data", wb_data, mq[0].result);
            chk("wb_dest", wb_dest, mq[0].dest);
            chk("wb_zero", wb_zero, mq[0].flags[6]);
         end
         chk("fcsr_flags", fcsr_flags, m_fcsr);
         m_add = '0;
`ifdef FPU_TRAP_EN
         chk("trap", trap, m_trap);
         chk("trap_cause", trap_cause, m_cause);
         m_h = m_hit();
         if (m_trap && trap_ack) begin
            mq.delete();
            m_trap = 1'b0;
         end else if (m_h) begin
            m_trap  = 1'b1;
            m_cause = mq[0].flags[5:0] & trap_mask;
            m_add   = mq[0].flags[5:0];
         end
`endif
         if (m_v && wb_ready) begin
            m_add = mq[0].flags[5:0];
            void'(mq.pop_front());
            n_out++;
         end
         if (in_valid && m_r) begin
            mq.push_back('{result: in_result, dest: in_dest, flags: in_flags});
            n_in++;
         end
         m_fcsr = (fcsr_clr ? 6'b0 : m_fcsr) | m_add;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] r, input logic [4:0] d, input logic [6:0] f);
      in_result = r;
      in_dest   = d;
      in_flags  = f;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      tick(); tick();
      chk("rst wb_valid", wb_valid, 0);
      chk("rst in_ready", in_ready, 1);
      chk("rst wb_data", wb_data, 0);
      chk("rst wb_dest", wb_dest, 0);
      chk("rst wb_zero", wb_zero, 0);
      chk("rst fcsr", fcsr_flags, 0);
`ifdef FPU_TRAP_EN
      chk("rst trap", trap, 0);
      chk("rst trap_cause", trap_cause, 0);
`endif
      rst_n = 1'b1;
      tick();

      // single entry, one-cycle presentation
      wb_ready = 1'b1;
      push(32'h3F80_0000, 5'd3, 7'h00);
      chk("t1 wb_valid", wb_valid, 1);
      chk("t1 wb_data", wb_data, 32'h3F80_0000);
      chk("t1 wb_dest", wb_dest, 3);
      tick();
      chk("t1 drained", wb_valid, 0);
      chk("t1 fcsr", fcsr_flags, 0);

      // back-pressure with DEPTH=2
      wb_ready = 1'b0;
      push(32'hA, 5'd4, 7'h00);
      push(32'hB, 5'd5, 7'h00);
      chk("t2 full in_ready", in_ready, 0);
      chk("t2 head A", wb_dest, 4);
      in_result = 32'hC; in_dest = 5'd6; in_flags = 7'h00; in_valid = 1'b1;
      tick();
      chk("t2 still full", in_ready, 0);
      wb_ready = 1'b1;
      tick();
      chk("t2 head B", wb_dest, 5);
      chk("t2 slot free", in_ready, 1);
      tick();
      chk("t2 head C", wb_dest, 6);
      chk("t2 C data", wb_data, 32'hC);
      in_valid = 1'b0;
      tick();
      chk("t2 drained", wb_valid, 0);

      // sticky flags and clear-vs-retire
      push(32'h1, 5'd1, 7'h04);
      tick();
      push(32'h2, 5'd2, 7'h02);
      tick();
      chk("t3 sticky", fcsr_flags, 6'h06);
      wb_ready = 1'b0;
      push(32'h3, 5'd3, 7'h01);
      chk("t3 held", fcsr_flags, 6'h06);
      fcsr_clr = 1'b1;
      wb_ready = 1'b1;
      tick();
      fcsr_clr = 1'b0;
      chk("t3 clr+retire", fcsr_flags, 6'h01);
      chk("t3 drained", wb_valid, 0);

      // zero flag is presented but never sticky
      push(32'h0, 5'd9, 7'h40);
      chk("t4 wb_zero", wb_zero, 1);
      tick();
      chk("t4 fcsr", fcsr_flags, 6'h01);

`ifdef FPU_TRAP_EN
      // enabled exception queued behind a clean entry
      trap_mask = 6'h20;
      wb_ready  = 1'b0;
      push(32'h7, 5'd7, 7'h00);
      push(32'h8, 5'd8, 7'h20);
      wb_ready = 1'b1;
      tick();
      chk("t5 withheld", wb_valid, 0);
      chk("t5 no trap yet", trap, 0);
      tick();
      chk("t5 trap", trap, 1);
      chk("t5 cause", trap_cause, 6'h20);
      chk("t5 in_ready", in_ready, 0);
      chk("t5 fcsr", fcsr_flags, 6'h21);
      tick();
      chk("t5 trap held", trap, 1);
      chk("t5 no write", wb_valid, 0);
      trap_ack = 1'b1;
      tick();
      trap_ack = 1'b0;
      chk("t5 trap clr", trap, 0);
      chk("t5 ready back", in_ready, 1);
      chk("t5 flushed", wb_valid, 0);
      trap_mask = 6'h00;
      tick();
`endif

      // reset mid-burst
      wb_ready = 1'b0;
      push(32'hDEAD_BEEF, 5'd10, 7'h08);
      push(32'h1234_5678, 5'd11, 7'h00);
      rst_n = 1'b0;
      #1;
      chk("t6 wb_valid", wb_valid, 0);
      chk("t6 in_ready", in_ready, 1);
      chk("t6 wb_data", wb_data, 0);
      chk("t6 wb_dest", wb_dest, 0);
      chk("t6 fcsr", fcsr_flags, 0);
      tick(); tick();
      rst_n    = 1'b1;
      wb_ready = 1'b1;
      tick();
      chk("t6 no write", wb_valid, 0);
      tick();

      // random traffic, checked cycle by cycle against the model
      n_in  = 0;
      n_out = 0;
      for (int i = 0; i < 100; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_result = $urandom;
         in_dest   = 5'($urandom_range(0, 31));
         in_flags  = 7'($urandom_range(0, 127));
         wb_ready  = ($urandom_range(0, 3) != 0);
         fcsr_clr  = ($urandom_range(0, 15) == 0);
         tick();
      end
      in_valid = 1'b0;
      fcsr_clr = 1'b0;
      wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("t7 all retired", n_out, n_in);
      chk("t7 model empty", mq.size(), 0);
      chk("t7 dut empty", wb_valid, 0);
      chk("t7 traffic seen", (n_in > 10), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
